// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Unsigned operand support is compiled in only when BOOTH_UNSIGNED_EN is defined.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    PA,
    P2A,
    MA,
    M2A
  } digit_op_t;

  // Unsigned operands need one extra digit so the zero-extended top bits
  // are recoded as a non-negative final digit.
  function automatic int booth_digits(input int width, input logic is_signed);
    return is_signed ? (width / 2) : (width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps multiplier bit triple (b[2i+1], b[2i], b[2i-1])
// to the partial-product operation. Purely combinational.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] i_triple,
  output digit_op_t  o_op
);

  always_comb begin
    o_op = ZERO;
    case (i_triple)
      3'b000, 3'b111: o_op = ZERO;
      3'b001, 3'b010: o_op = PA;
      3'b011:         o_op = P2A;
      3'b100:         o_op = M2A;
      3'b101, 3'b110: o_op = MA;
      default:        o_op = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define BOOTH_UNSIGNED_EN to add the is_signed port and unsigned operation.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam int MPLR_W = WIDTH + 3;
  localparam int CNT_W  = $clog2(WIDTH / 2 + 2);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_mult_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_mcand;
  logic [MPLR_W-1:0]   r_mplr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last;
  logic [2*WIDTH-1:0]  r_product;

  logic                w_signed;
  logic                w_accept;
  logic                w_last_digit;
  digit_op_t           w_op;
  logic [ACC_W-1:0]    w_pp;
  logic [ACC_W-1:0]    w_acc_next;

`ifdef BOOTH_UNSIGNED_EN
  assign w_signed = is_signed;
`else
  assign w_signed = 1'b1;
`endif

  assign in_ready     = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid    = (r_state == DONE);
  assign product      = r_product;
  assign w_accept     = in_valid && in_ready;
  assign w_last_digit = (r_cnt == r_last);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_next = BUSY;
      BUSY: if (w_last_digit) w_state_next = DONE;
      DONE: if (out_ready) w_state_next = in_valid ? BUSY : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  booth_r4_encoder u_encoder (
    .i_triple (r_mplr[2:0]),
    .o_op     (w_op)
  );

  always_comb begin
    w_pp = '0;
    case (w_op)
      ZERO:    w_pp = '0;
      PA:      w_pp = r_mcand;
      P2A:     w_pp = r_mcand << 1;
      MA:      w_pp = -r_mcand;
      M2A:     w_pp = -(r_mcand << 1);
      default: w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

  // The multiplicand is pre-shifted by two each digit so the accumulator
  // never needs a variable shift; the multiplier drains toward bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_mcand <= {{(ACC_W - WIDTH){w_signed & multiplicand[WIDTH-1]}}, multiplicand};
      r_mplr  <= {{2{w_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
      r_last  <= CNT_W'(booth_digits(WIDTH, w_signed) - 1);
    end else if (r_state == BUSY) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 2;
      r_mplr  <= r_mplr >> 2;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last_digit) begin
        r_product <= w_acc_next[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: an 8-bit and a 16-bit instance, expected
// products queued at acceptance and compared by monitors at each output handoff.
module tb_booth_mult_seq;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          d;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, sgn8;
  logic [7:0]  mcand8, mplr8;
  logic [15:0] product8;
  logic [15:0] exp8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, sgn16;
  logic [15:0] mcand16, mplr16;
  logic [31:0] product16;
  logic [31:0] exp16;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  item_t q8[$];
  item_t q16[$];
  item_t it8, it16;
  bit    pres8 = 0, pres16 = 0;
  int    first8 = 0, first16 = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid8),
    .in_ready     (in_ready8),
    .multiplicand (mcand8),
    .multiplier   (mplr8),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed    (sgn8),
`endif
    .out_valid    (out_valid8),
    .out_ready    (out_ready8),
    .product      (product8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid16),
    .in_ready     (in_ready16),
    .multiplicand (mcand16),
    .multiplier   (mplr16),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed    (sgn16),
`endif
    .out_valid    (out_valid16),
    .out_ready    (out_ready16),
    .product      (product16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
    longint la, lb, p;
    la = longint'(signed'(a));
    lb = longint'(signed'(b));
    p  = la * lb;
    return p[31:0];
  endfunction

  // Monitor for the 8-bit instance: acceptance pushes, handoff pops.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q8.delete();
      pres8 = 0;
    end else begin
      if (out_valid8 && !pres8) begin
        pres8  = 1;
        first8 = cyc;
        check("out8_has_request", 32'(q8.size() != 0), 32'd1);
      end
      if (out_valid8 && out_ready8) begin
        pres8 = 0;
        if (q8.size() != 0) begin
          it8 = q8.pop_front();
          check("product8", 32'(product8), it8.exp);
          check("latency8", 32'(first8 - it8.acc), 32'(it8.d));
        end
      end
      if (in_valid8 && in_ready8)
        q8.push_back('{exp: 32'(exp8), acc: cyc + 1, d: (sgn8 ? 4 : 5)});
    end
  end

  // Monitor for the 16-bit instance.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q16.delete();
      pres16 = 0;
    end else begin
      if (out_valid16 && !pres16) begin
        pres16  = 1;
        first16 = cyc;
        check("out16_has_request", 32'(q16.size() != 0), 32'd1);
      end
      if (out_valid16 && out_ready16) begin
        pres16 = 0;
        if (q16.size() != 0) begin
          it16 = q16.pop_front();
          check("product16", product16, it16.exp);
          check("latency16", 32'(first16 - it16.acc), 32'(it16.d));
        end
      end
      if (in_valid16 && in_ready16)
        q16.push_back('{exp: exp16, acc: cyc + 1, d: 8});
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       input logic [15:0] exp);
    bit done = 0;
    mcand8 = a; mplr8 = b; sgn8 = sgn; exp8 = exp; in_valid8 = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready8) done = 1;
    end
    check("send8_accepted", 32'(done), 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    bit done = 0;
    mcand16 = a; mplr16 = b; exp16 = exp; in_valid16 = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready16) done = 1;
    end
    if (!done) check("send16_accepted", 32'(done), 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() + q16.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drained", 32'(q8.size() + q16.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 1; sgn8 = 1; mcand8 = '0; mplr8 = '0; exp8 = '0;
    in_valid16 = 0; out_ready16 = 1; sgn16 = 1; mcand16 = '0; mplr16 = '0; exp16 = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid8", 32'(out_valid8), 32'd0);
    check("reset_in_ready8", 32'(in_ready8), 32'd1);
    check("reset_product8", 32'(product8), 32'd0);
    check("reset_out_valid16", 32'(out_valid16), 32'd0);
    check("reset_product16", product16, 32'd0);
    @(posedge clk);
    #2;

    // Signed 8-bit vectors issued back to back.
    send8(8'd27,  8'hF1, 1'b1, 16'hFE6B);   // 27 * -15 = -405
    send8(8'h80,  8'h80, 1'b1, 16'h4000);   // -128 * -128 = 16384
    send8(8'h80,  8'd10, 1'b1, 16'hFB00);   // -128 * 10 = -1280
    send8(8'h7F,  8'h7F, 1'b1, 16'h3F01);   // 127 * 127 = 16129
    send8(8'hFF,  8'h7F, 1'b1, 16'hFF81);   // -1 * 127 = -127
    send8(8'd100, 8'hFD, 1'b1, 16'hFED4);   // 100 * -3 = -300
    send8(8'd0,   8'hB3, 1'b1, 16'h0000);   // 0 * -77 = 0
`ifdef BOOTH_UNSIGNED_EN
    send8(8'hFF,  8'hFF, 1'b0, 16'hFE01);   // 255 * 255 unsigned = 65025
    send8(8'hFF,  8'hFF, 1'b1, 16'h0001);   // -1 * -1 signed = 1
`endif
    in_valid8 = 0;
    drain();

    // Consumer stall: result must hold and new offers must be refused.
    @(posedge clk);
    #2 out_ready8 = 0;
    send8(8'd12, 8'd12, 1'b1, 16'h0090);    // 12 * 12 = 144
    in_valid8 = 0;
    for (int i = 0; i < 20 && !out_valid8; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("hold_out_valid", 32'(out_valid8), 32'd1);
      check("hold_product", 32'(product8), 32'h0090);
      check("hold_in_ready", 32'(in_ready8), 32'd0);
      @(posedge clk);
      #2;
      if (k == 0) begin
        mcand8 = 8'd3; mplr8 = 8'd3; exp8 = 16'h0009; in_valid8 = 1;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2 in_valid8 = 0; out_ready8 = 1;
    @(negedge clk);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("after_handoff_out_valid", 32'(out_valid8), 32'd0);
    check("after_handoff_in_ready", 32'(in_ready8), 32'd1);
    check("after_handoff_product", 32'(product8), 32'h0090);

    // Abort: reset lands in the second BUSY cycle.
    @(posedge clk);
    #2;
    send8(8'd50, 8'd50, 1'b1, 16'h09C4);
    in_valid8 = 0;
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid8), 32'd0);
    check("abort_in_ready", 32'(in_ready8), 32'd1);
    check("abort_product", 32'(product8), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_late_valid", 32'(out_valid8), 32'd0);
    @(posedge clk);
    #2;

    // 16-bit: corner vectors then a continuous random stream.
    send16(16'h8000, 16'h8000, 32'h4000_0000);
    send16(16'h7FFF, 16'h8000, 32'hC000_8000);
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send16(ra, rb, ref16(ra, rb));
    end
    in_valid16 = 0;
    drain();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; even, >= 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port multiplicand  input  WIDTH  operand A.
REQ-007 SHALL have port multiplier  input  WIDTH  operand B.
REQ-008 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; present only with BOOTH_UNSIGNED_EN.
REQ-009 SHALL have port out_valid  output  1  product valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts product.
REQ-011 SHALL have port product  output  2*WIDTH  registered result.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-014 SHALL capture multiplicand, multiplier and is_signed only on in_valid && in_ready; later input changes are ignored until the next acceptance.
REQ-015 SHALL retire one radix-4 Booth digit per BUSY cycle: D = WIDTH/2 digits for signed, WIDTH/2+1 for unsigned, with the multiplier zero-extended by 2 bits.
REQ-016 SHALL select each partial product from {0, +A, +2A, -A, -2A} per standard radix-4 recoding of bit triple (b[2i+1], b[2i], b[2i-1]), with b[-1]=0.
REQ-017 SHALL accumulate in a 2*WIDTH+2-bit signed accumulator; product = low 2*WIDTH bits, exact for all operand values.
REQ-018 SHALL assert out_valid exactly D cycles after the acceptance edge, with state==DONE.
REQ-019 SHALL hold product and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready, go to BUSY if a new operand pair is accepted on the same edge, else go to IDLE with out_valid=0; this gives back-to-back throughput of one result per D+0 idle cycles.
REQ-021 SHALL produce WIDTH=8 signed -128*-128 = 16384 without overflow.
REQ-022 SHALL leave product holding its last value after handoff until the next result.

Reset
REQ-023 SHALL, on rst high at a clk edge, set state=IDLE, out_valid=0, product=0 and clear the accumulator and digit counter.
REQ-024 SHALL abandon any in-flight operation on rst, with no out_valid pulse afterwards for it.
REQ-025 SHALL take precedence over any handshake that occurs in the same cycle.

Configuration
REQ-026 SHALL, with BOOTH_UNSIGNED_EN defined, provide the is_signed port and support unsigned operation per REQ-015.
REQ-027 SHALL, without BOOTH_UNSIGNED_EN, omit is_signed, treat all operands as signed, and always use D = WIDTH/2.

Structure
REQ-028 SHALL place the FSM state enum, the Booth digit-op enum (ZERO, PA, P2A, MA, M2A) and a function returning D in package booth_pkg.
REQ-029 SHALL instantiate one combinational sub-module booth_r4_encoder (3-bit triple in, digit-op out).
REQ-030 SHALL raise an elaboration error for odd WIDTH or WIDTH < 4.

Verification
REQ-031 SHALL check: WIDTH=8, 27 * -15 signed -> product 0xFE6B (-405), out_valid 4 cycles after acceptance.
REQ-032 SHALL check: -128 * -128 signed -> 0x4000; -128 * 10 -> 0xFB00 (-1280).
REQ-033 SHALL check with macro: 255 * 255, is_signed=0 -> 0xFE01 (65025) after 5 cycles; same operands with is_signed=1 -> 0x0001.
REQ-034 SHALL check: out_ready held low 3 cycles after out_valid -> product and out_valid stable, in_ready=0, new in_valid ignored.
REQ-035 SHALL check: rst pulsed during the 2nd BUSY cycle -> next cycle IDLE, product=0, out_valid never asserted for the aborted operation.
REQ-036 SHALL check: continuous in_valid and out_ready, WIDTH=16, 100 random signed pairs -> all products match the reference model, with no bubble between DONE and the next BUSY.
